cordic_sincos_frontend: RTL and testbench

Full-circle sine/cosine requester that drives the pipelined CORDIC core. It accepts a binary phase over a valid/ready handshake and folds it into quadrant I, because the core only produces quadrant-I results. It issues the folded angle to the core in rotation mode, then applies the quadrant sign/swap correction to each returned result. Results go out through an in-order result FIFO with backpressure. Credit accounting guarantees no core result is ever dropped.

---
 rtl/cordic_sincos_frontend.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_cordic_sincos_frontend.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sincos_frontend.sv
// -----------------------------------------------------------------------------
// cordic_sincos_frontend
//
// Full-circle sine/cosine requester sitting in front of a pipelined CORDIC
// core that only understands quadrant-I angles. A binary phase is accepted
// over a valid/ready handshake and folded into quadrant I. It is held in a
// one-entry stage register and then issued to the core in rotation mode. The
// quadrant travels alongside in a tag FIFO. Each returned core result is
// un-folded with the quadrant's sign/swap rule and pushed into an in-order
// result FIFO. A credit counter keeps the number of staged + in-core +
// buffered results at or below DEPTH, so a core result is never dropped.
//
// Ports
//   clk, reset               clock (rising edge), async active-high reset
//   in_valid/in_ready        request handshake
//   in_phase                 unsigned binary angle, 2^BIT_WIDTH == 2*pi
//   out_valid/out_ready      result handshake (show-ahead FIFO head)
//   out_cos, out_sin         signed results, zero while out_valid is low
//   err                      sticky: core_done with no tag, or result overflow
//   core_start               one-cycle issue strobe to the core
//   core_angle/x/y, core_mode  core operands (rotation mode, x = K, y = 0)
//   core_ready               core can take an operand this cycle
//   core_done                core result valid this cycle
//   core_out_x, core_out_y   quadrant-I cos/sin from the core
// -----------------------------------------------------------------------------
module cordic_sincos_frontend #(
    parameter int                   BIT_WIDTH = 16,
    parameter logic [BIT_WIDTH-1:0] K         = 16'd19898,
    parameter logic [BIT_WIDTH-1:0] HALF_PI   = 16'd25736,
    parameter int                   DEPTH     = 32
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 in_valid,
    input  logic [BIT_WIDTH-1:0] in_phase,
    output logic                 in_ready,

    output logic                 out_valid,
    output logic [BIT_WIDTH-1:0] out_cos,
    output logic [BIT_WIDTH-1:0] out_sin,
    input  logic                 out_ready,

    output logic                 err,

    output logic                 core_start,
    output logic [BIT_WIDTH-1:0] core_angle,
    output logic [BIT_WIDTH-1:0] core_x,
    output logic [BIT_WIDTH-1:0] core_y,
    output logic                 core_mode,
    input  logic                 core_ready,
    input  logic                 core_done,
    input  logic [BIT_WIDTH-1:0] core_out_x,
    input  logic [BIT_WIDTH-1:0] core_out_y
);

    localparam int PROD_WIDTH = 2 * BIT_WIDTH - 2;
    localparam int CNT_WIDTH  = $clog2(DEPTH + 1);
    localparam int PTR_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [PTR_WIDTH-1:0] LAST_PTR  = PTR_WIDTH'(DEPTH - 1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE   = PTR_WIDTH'(1);

    // Circular pointer advance; DEPTH need not be a power of two.
    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_ONE;
    endfunction

    // -------------------------------------------------------------------------
    // Quadrant fold
    // -------------------------------------------------------------------------
    logic [1:0]            in_quad;
    logic [BIT_WIDTH-3:0]  in_residual;
    logic [PROD_WIDTH-1:0] angle_product;
    logic [BIT_WIDTH-1:0]  folded_angle;
    logic [BIT_WIDTH-3:0]  unused_angle_frac;

    assign in_quad     = in_phase[BIT_WIDTH-1 -: 2];
    assign in_residual = in_phase[BIT_WIDTH-3:0];

    // The residual spans [0, pi/2) in 2^(BIT_WIDTH-2) steps; scaling by
    // HALF_PI and dropping the low BIT_WIDTH-2 bits maps it onto core angle
    // units. The product is wide enough that nothing overflows, and the
    // truncated result stays strictly below HALF_PI.
    assign angle_product = {{BIT_WIDTH{1'b0}}, in_residual}
                         * {{(BIT_WIDTH-2){1'b0}}, HALF_PI};
    assign {folded_angle, unused_angle_frac} = angle_product;

    // -------------------------------------------------------------------------
    // Handshake and credit-derived control
    // -------------------------------------------------------------------------
    logic                 stage_valid;
    logic [BIT_WIDTH-1:0] stage_angle;
    logic [1:0]           stage_quad;
    logic [CNT_WIDTH-1:0] credits;
    logic                 accept;
    logic                 pop;
    logic [CNT_WIDTH-1:0] res_count;

    assign core_start = stage_valid & core_ready;
    assign in_ready   = ~reset & (credits != '0) & (~stage_valid | core_ready);
    assign accept     = in_valid & in_ready;
    assign out_valid  = (res_count != '0);
    assign pop        = out_valid & out_ready;

    assign core_angle = stage_angle;
    assign core_x     = stage_valid ? K : '0;
    assign core_y     = '0;
    assign core_mode  = 1'b0;

    // Stage register. A new accept can refill the stage in the same cycle the
    // previous entry is issued, which is what sustains one request per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_valid <= 1'b0;
            stage_angle <= '0;
            stage_quad  <= '0;
        end else if (accept) begin
            stage_valid <= 1'b1;
            stage_angle <= folded_angle;
            stage_quad  <= in_quad;
        end else if (core_start) begin
            stage_valid <= 1'b0;
        end
    end

    // Credit counter: one credit per request from accept until its result is
    // popped, so the result FIFO can always absorb everything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credits <= DEPTH_CNT;
        end else begin
            case ({accept, pop})
                2'b10:   credits <= credits - CNT_ONE;
                2'b01:   credits <= credits + CNT_ONE;
                default: credits <= credits;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Tag FIFO: quadrant of each issued request, popped on core_done. Results
    // are paired with quadrants purely by order, independent of core latency.
    // -------------------------------------------------------------------------
    logic [1:0]           tag_mem [DEPTH];
    logic [PTR_WIDTH-1:0] tag_wr_ptr;
    logic [PTR_WIDTH-1:0] tag_rd_ptr;
    logic [CNT_WIDTH-1:0] tag_count;
    logic                 tag_empty;
    logic                 tag_full;
    logic                 tag_write;
    logic                 tag_pop;
    logic [1:0]           head_quad;

    assign tag_empty = (tag_count == '0);
    assign tag_full  = (tag_count == DEPTH_CNT);
    assign tag_write = core_start & ~tag_full;
    assign tag_pop   = core_done & ~tag_empty;
    assign head_quad = tag_mem[tag_rd_ptr];

    // Tag storage carries no reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (tag_write) begin
            tag_mem[tag_wr_ptr] <= stage_quad;
        end
    end

    // Tag pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
            tag_count  <= '0;
        end else begin
            if (tag_write) begin
                tag_wr_ptr <= next_ptr(tag_wr_ptr);
            end
            if (tag_pop) begin
                tag_rd_ptr <= next_ptr(tag_rd_ptr);
            end
            case ({tag_write, tag_pop})
                2'b10:   tag_count <= tag_count + CNT_ONE;
                2'b01:   tag_count <= tag_count - CNT_ONE;
                default: tag_count <= tag_count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Quadrant correction of the returned result
    // -------------------------------------------------------------------------
    logic [BIT_WIDTH-1:0] corr_cos;
    logic [BIT_WIDTH-1:0] corr_sin;

    // Rotating a quadrant-I result by q*pi/2 is a swap plus sign flips. Core
    // outputs are non-negative and below 2^(BIT_WIDTH-1), so negation is safe.
    always_comb begin
        corr_cos = core_out_x;
        corr_sin = core_out_y;
        case (head_quad)
            2'd0: begin
                corr_cos = core_out_x;
                corr_sin = core_out_y;
            end
            2'd1: begin
                corr_cos = -core_out_y;
                corr_sin = core_out_x;
            end
            2'd2: begin
                corr_cos = -core_out_x;
                corr_sin = -core_out_y;
            end
            default: begin
                corr_cos = core_out_y;
                corr_sin = -core_out_x;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Result FIFO (show-ahead)
    // -------------------------------------------------------------------------
    logic [BIT_WIDTH-1:0] res_cos_mem [DEPTH];
    logic [BIT_WIDTH-1:0] res_sin_mem [DEPTH];
    logic [PTR_WIDTH-1:0] res_wr_ptr;
    logic [PTR_WIDTH-1:0] res_rd_ptr;
    logic                 res_full;
    logic                 res_push;
    logic                 res_write;

    assign res_full  = (res_count == DEPTH_CNT);
    assign res_push  = tag_pop;
    assign res_write = res_push & ~res_full;

    // Outputs read zero whenever the FIFO is empty, which also gives the
    // required zero values straight out of reset.
    assign out_cos = out_valid ? res_cos_mem[res_rd_ptr] : '0;
    assign out_sin = out_valid ? res_sin_mem[res_rd_ptr] : '0;

    // Result storage; validity comes from the pointers and count below.
    always_ff @(posedge clk) begin
        if (res_write) begin
            res_cos_mem[res_wr_ptr] <= corr_cos;
            res_sin_mem[res_wr_ptr] <= corr_sin;
        end
    end

    // Result pointers and occupancy. A push that meets a full FIFO is dropped
    // (and flagged below) even if a pop happens the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_wr_ptr <= '0;
            res_rd_ptr <= '0;
            res_count  <= '0;
        end else begin
            if (res_write) begin
                res_wr_ptr <= next_ptr(res_wr_ptr);
            end
            if (pop) begin
                res_rd_ptr <= next_ptr(res_rd_ptr);
            end
            case ({res_write, pop})
                2'b10:   res_count <= res_count + CNT_ONE;
                2'b01:   res_count <= res_count - CNT_ONE;
                default: res_count <= res_count;
            endcase
        end
    end

    // Sticky error: a result with no matching tag, or a result that could
    // not be buffered. Only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if ((core_done & tag_empty) | (res_push & res_full)) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cordic_sincos_frontend.sv
// -----------------------------------------------------------------------------
// tb_cordic_sincos_frontend
//
// Bench for cordic_sincos_frontend. Contains a behavioural pipelined CORDIC
// core (fixed latency, real-valued cos/sin of the issued angle) and a
// reference monitor that records every accepted phase and compares each
// popped result against the ideal full-circle cos/sin of that phase.
// -----------------------------------------------------------------------------
module tb_cordic_sincos_frontend;

    localparam int          BW          = 16;
    localparam int          DEPTH       = 32;
    localparam int          LAT         = 5;
    localparam logic [15:0] K_VAL       = 16'd19898;
    localparam logic [15:0] HALF_PI_VAL = 16'd25736;
    localparam int          TOL         = 4;
    localparam int          NUM_VECS    = 8;
    localparam real         PI          = 3.14159265358979;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [BW-1:0] in_phase;
    logic          in_ready;
    logic          out_valid;
    logic [BW-1:0] out_cos;
    logic [BW-1:0] out_sin;
    logic          out_ready;
    logic          err;
    logic          core_start;
    logic [BW-1:0] core_angle;
    logic [BW-1:0] core_x;
    logic [BW-1:0] core_y;
    logic          core_mode;
    logic          core_ready;
    logic          core_done;
    logic [BW-1:0] core_out_x;
    logic [BW-1:0] core_out_y;
    logic          spurious_done;

    int n_compared;
    int n_mismatched;

    logic [15:0] exp_q [$];

    typedef struct {
        logic [15:0] phase;
        int          exp_cos;
        int          exp_sin;
    } vec_t;

    vec_t vecs [NUM_VECS];

    cordic_sincos_frontend #(
        .BIT_WIDTH (BW),
        .K         (K_VAL),
        .HALF_PI   (HALF_PI_VAL),
        .DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_phase   (in_phase),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_cos    (out_cos),
        .out_sin    (out_sin),
        .out_ready  (out_ready),
        .err        (err),
        .core_start (core_start),
        .core_angle (core_angle),
        .core_x     (core_x),
        .core_y     (core_y),
        .core_mode  (core_mode),
        .core_ready (core_ready),
        .core_done  (core_done),
        .core_out_x (core_out_x),
        .core_out_y (core_out_y)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hang guard: the test itself needs only a few thousand cycles.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int round_real(input real x);
        return $rtoi($floor(x + 0.5));
    endfunction

    // Ideal full-circle reference, amplitude 16384.
    function automatic int ref_cos(input logic [15:0] p);
        real th;
        th = 2.0 * PI * real'(p) / 65536.0;
        return round_real(16384.0 * $cos(th));
    endfunction

    function automatic int ref_sin(input logic [15:0] p);
        real th;
        th = 2.0 * PI * real'(p) / 65536.0;
        return round_real(16384.0 * $sin(th));
    endfunction

    // Core model arithmetic: angle unit is 1/16384 rad (HALF_PI ~ pi/2*16384).
    function automatic logic [15:0] core_cos(input logic [15:0] a);
        return 16'(round_real(16384.0 * $cos(real'(a) / 16384.0)));
    endfunction

    function automatic logic [15:0] core_sin(input logic [15:0] a);
        return 16'(round_real(16384.0 * $sin(real'(a) / 16384.0)));
    endfunction

    task automatic check_output(input string name, input int actual, input int expected, input int tol);
        n_compared++;
        if (actual > expected + tol || actual < expected - tol) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d) at %0t", name, actual, expected, tol, $time);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then let the
    // combinational outputs settle before the caller looks at them.
    task automatic apply_stimulus(input logic v, input logic [15:0] p, input logic cr, input logic ordy);
        @(posedge clk);
        #1;
        in_valid   = v;
        in_phase   = p;
        core_ready = cr;
        out_ready  = ordy;
        #1;
    endtask

    // Behavioural pipelined core: fixed latency LAT, reset together with the DUT.
    logic        pipe_v [LAT];
    logic [15:0] pipe_x [LAT];
    logic [15:0] pipe_y [LAT];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_x[i] <= '0;
                pipe_y[i] <= '0;
            end
        end else begin
            pipe_v[0] <= core_start;
            pipe_x[0] <= core_cos(core_angle);
            pipe_y[0] <= core_sin(core_angle);
            for (int i = 1; i < LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_x[i] <= pipe_x[i-1];
                pipe_y[i] <= pipe_y[i-1];
            end
        end
    end

    assign core_done  = pipe_v[LAT-1] | spurious_done;
    assign core_out_x = pipe_x[LAT-1];
    assign core_out_y = pipe_y[LAT-1];

    // Mid-cycle monitor: records accepted phases in order, scores every popped
    // result against the ideal reference, and checks the operands on issue.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (core_start) begin
                check_output("core_x", int'(core_x), int'(K_VAL), 0);
                check_output("core_y", int'(core_y), 0, 0);
                check_output("core_mode", int'(core_mode), 0, 0);
                if (core_angle >= HALF_PI_VAL) begin
                    check_output("core_angle_range", int'(core_angle), int'(HALF_PI_VAL) - 1, 0);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_phase);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL mon_order: result popped with 0 outstanding requests, expected at least 1");
                end else begin
                    logic [15:0] p;
                    p = exp_q.pop_front();
                    check_output("mon_cos", int'($signed(out_cos)), ref_cos(p), TOL);
                    check_output("mon_sin", int'($signed(out_sin)), ref_sin(p), TOL);
                end
            end
        end
    end

    // Fill under backpressure until credits run out, then drain everything.
    task automatic run_backpressure(input string tag);
        int accepts;
        int pops;
        accepts = 0;
        for (int i = 0; i < DEPTH + 20; i++) begin
            apply_stimulus(1'b1, 16'($urandom), 1'b1, 1'b0);
            if (in_ready) accepts++;
        end
        check_output({tag, "_accepts"}, accepts, DEPTH, 0);
        check_output({tag, "_in_ready_low"}, int'(in_ready), 0, 0);
        repeat (LAT + 4) apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        check_output({tag, "_full_valid"}, int'(out_valid), 1, 0);
        if (exp_q.size() > 0) begin
            check_output({tag, "_hold_cos_a"}, int'($signed(out_cos)), ref_cos(exp_q[0]), TOL);
            apply_stimulus(1'b0, '0, 1'b1, 1'b0);
            check_output({tag, "_hold_cos_b"}, int'($signed(out_cos)), ref_cos(exp_q[0]), TOL);
            check_output({tag, "_hold_sin_b"}, int'($signed(out_sin)), ref_sin(exp_q[0]), TOL);
        end
        pops = 0;
        for (int i = 0; i < DEPTH + 10; i++) begin
            apply_stimulus(1'b0, '0, 1'b1, 1'b1);
            if (out_valid) pops++;
        end
        check_output({tag, "_pops"}, pops, DEPTH, 0);
        check_output({tag, "_err"}, int'(err), 0, 0);
    endtask

    initial begin
        int n;
        int acc;
        int stale;
        logic v;

        vecs[0] = '{16'h0000,  16384,      0};
        vecs[1] = '{16'h4000,      0,  16384};
        vecs[2] = '{16'h8000, -16384,      0};
        vecs[3] = '{16'hC000,      0, -16384};
        vecs[4] = '{16'h2000,  11585,  11585};
        vecs[5] = '{16'hA000, -11585, -11585};
        vecs[6] = '{16'h6000, -11585,  11585};
        vecs[7] = '{16'h1555,  14189,   8192};

        n_compared    = 0;
        n_mismatched  = 0;
        reset         = 1'b1;
        in_valid      = 1'b0;
        in_phase      = '0;
        core_ready    = 1'b1;
        out_ready     = 1'b0;
        spurious_done = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_in_ready", int'(in_ready), 0, 0);
        check_output("rst_out_valid", int'(out_valid), 0, 0);
        check_output("rst_core_start", int'(core_start), 0, 0);
        check_output("rst_err", int'(err), 0, 0);
        check_output("rst_out_cos", int'(out_cos), 0, 0);
        check_output("rst_out_sin", int'(out_sin), 0, 0);
        check_output("rst_core_angle", int'(core_angle), 0, 0);
        check_output("rst_core_x", int'(core_x), 0, 0);
        check_output("rst_core_y", int'(core_y), 0, 0);
        reset = 1'b0;
        apply_stimulus(1'b0, '0, 1'b1, 1'b1);
        check_output("rst_in_ready_rise", int'(in_ready), 1, 0);

        // Latency of a single phase-0 request.
        apply_stimulus(1'b1, 16'h0000, 1'b1, 1'b1);
        check_output("lat_accept", int'(in_ready), 1, 0);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            apply_stimulus(1'b0, '0, 1'b1, 1'b1);
            n++;
            if (out_valid) break;
        end
        check_output("lat_cycles", n, LAT + 2, 0);
        check_output("lat_cos", int'($signed(out_cos)), 16384, TOL);
        check_output("lat_sin", int'($signed(out_sin)), 0, TOL);
        repeat (3) apply_stimulus(1'b0, '0, 1'b1, 1'b1);

        // Table vectors issued back to back, popped on consecutive cycles.
        for (int i = 0; i < NUM_VECS; i++) begin
            apply_stimulus(1'b1, vecs[i].phase, 1'b1, 1'b0);
            check_output("tbl_in_ready", int'(in_ready), 1, 0);
        end
        repeat (LAT + 3) apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < NUM_VECS; i++) begin
            apply_stimulus(1'b0, '0, 1'b1, 1'b1);
            check_output("tbl_valid", int'(out_valid), 1, 0);
            check_output("tbl_cos", int'($signed(out_cos)), vecs[i].exp_cos, TOL);
            check_output("tbl_sin", int'($signed(out_sin)), vecs[i].exp_sin, TOL);
        end
        apply_stimulus(1'b0, '0, 1'b1, 1'b1);
        check_output("tbl_empty", int'(out_valid), 0, 0);

        // Credit exhaustion under full backpressure.
        run_backpressure("bp");

        // Random phases with core_ready and out_ready toggling.
        acc = 0;
        for (int c = 0; c < 5000 && acc < 200; c++) begin
            v = ($urandom_range(0, 3) != 0);
            apply_stimulus(v, 16'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
            if (v && in_ready) acc++;
        end
        check_output("rand_accepts", acc, 200, 0);
        repeat (DEPTH + LAT + 10) apply_stimulus(1'b0, '0, 1'b1, 1'b1);
        check_output("rand_drained", exp_q.size(), 0, 0);
        check_output("rand_err", int'(err), 0, 0);

        // Reset with requests in flight.
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, 16'($urandom), 1'b1, 1'b0);
        end
        repeat (3) apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        check_output("mid_pre_valid", int'(out_valid), 1, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_output("mid_out_valid", int'(out_valid), 0, 0);
        check_output("mid_in_ready", int'(in_ready), 0, 0);
        check_output("mid_core_start", int'(core_start), 0, 0);
        check_output("mid_out_cos", int'(out_cos), 0, 0);
        check_output("mid_out_sin", int'(out_sin), 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        stale = 0;
        for (int i = 0; i < 30; i++) begin
            apply_stimulus(1'b0, '0, 1'b1, 1'b1);
            if (out_valid) stale++;
        end
        check_output("mid_stale_valid", stale, 0, 0);
        check_output("mid_err", int'(err), 0, 0);
        run_backpressure("mid_bp");

        // A core_done with no outstanding tag is flagged and discarded.
        @(posedge clk);
        #1;
        spurious_done = 1'b1;
        @(posedge clk);
        #1;
        spurious_done = 1'b0;
        #1;
        check_output("spur_err", int'(err), 1, 0);
        check_output("spur_no_valid", int'(out_valid), 0, 0);
        repeat (4) apply_stimulus(1'b0, '0, 1'b1, 1'b1);
        check_output("spur_err_sticky", int'(err), 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
